// File: rtl/mips_int_ctrl.sv
// External interrupt front-end for the mips core.
// The raw asynchronous interrupter line is synchronised and debounced, and
// each qualified pulse becomes one held request. The block handshakes with
// the core (ack on exception entry, eret on return), saves the resume PC and
// presents a fixed handler vector. Nesting is not supported: a pulse that
// arrives while a request is pending or in service is counted as lost.
module mips_int_ctrl #(
    parameter int          SYNC_STAGES  = 2,
    parameter int          MIN_PULSE    = 2,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0008
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        interrupter,
    input  logic        int_en,
    input  logic        int_ack,
    input  logic        eret,
    input  logic [31:0] resume_pc,
    output logic        int_req,
    output logic [31:0] handler_addr,
    output logic [31:0] epc,
    output logic        in_service,
    output logic [7:0]  lost_cnt
);

    // Counter just wide enough to hold MIN_PULSE.
    localparam int CW = (MIN_PULSE < 2) ? 1 : $clog2(MIN_PULSE + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_hi;
    logic [CW-1:0]          cnt_reg;
    logic                   pulse_event;
    state_t                 state_reg;
    logic [31:0]            epc_reg;
    logic [7:0]             lost_reg;
    logic [7:0]             lost_next;

    assign sync_hi = sync_reg[SYNC_STAGES-1];

    // One event per pulse: fires on the edge the counter reaches MIN_PULSE,
    // and cannot fire again until sync_hi drops and clears the counter.
    assign pulse_event = sync_hi && (cnt_reg == CW'(MIN_PULSE - 1));

    // Saturating increment of the lost-pulse counter.
    assign lost_next = (lost_reg == 8'hFF) ? lost_reg : lost_reg + 8'd1;

    // Shift the raw line through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], interrupter};
        end
    end

    // Count consecutive synchronised-high cycles, saturating at MIN_PULSE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (!sync_hi) begin
            cnt_reg <= '0;
        end else if (cnt_reg != CW'(MIN_PULSE)) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    // Request/service state machine with EPC capture and lost-pulse count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            epc_reg   <= 32'h0;
            lost_reg  <= 8'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pulse_event) begin
                        state_reg <= PEND;
                    end
                end
                PEND: begin
                    // A masked ack is not an exception entry, so it is ignored.
                    if (int_ack && int_en) begin
                        state_reg <= SERVICE;
                        epc_reg   <= resume_pc;
                    end
                    if (pulse_event) begin
                        lost_reg <= lost_next;
                    end
                end
                SERVICE: begin
                    if (eret) begin
                        // A pulse landing on the return cycle is taken, not lost.
                        state_reg <= pulse_event ? PEND : IDLE;
                    end else if (pulse_event) begin
                        lost_reg <= lost_next;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign int_req      = (state_reg == PEND) && int_en;
    assign in_service   = (state_reg == SERVICE);
    assign epc          = epc_reg;
    assign lost_cnt     = lost_reg;
    assign handler_addr = HANDLER_ADDR;

endmodule

// File: tb/tb_mips_int_ctrl.sv
// Directed bench for mips_int_ctrl: glitch rejection, request latency,
// acknowledge, lost pulses, eret/event coincidence, enable masking,
// asynchronous reset mid-service and lost-count saturation.
module tb_mips_int_ctrl;

    logic        clk;
    logic        rst;
    logic        interrupter;
    logic        int_en;
    logic        int_ack;
    logic        eret;
    logic [31:0] resume_pc;
    logic        int_req;
    logic [31:0] handler_addr;
    logic [31:0] epc;
    logic        in_service;
    logic [7:0]  lost_cnt;

    int n_vec = 0;
    int n_err = 0;

    mips_int_ctrl #(
        .SYNC_STAGES (2),
        .MIN_PULSE   (2),
        .HANDLER_ADDR(32'h0000_0008)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .interrupter (interrupter),
        .int_en      (int_en),
        .int_ack     (int_ack),
        .eret        (eret),
        .resume_pc   (resume_pc),
        .int_req     (int_req),
        .handler_addr(handler_addr),
        .epc         (epc),
        .in_service  (in_service),
        .lost_cnt    (lost_cnt)
    );

    // 20 ns clock.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s: observed %h expected %h", n_vec, tag, obs, exp);
    endtask

    // Drive interrupter high for hi edges, then low for 4 edges.
    task automatic pulse(input int hi);
        interrupter = 1'b1;
        repeat (hi) tick();
        interrupter = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        rst         = 1'b1;
        interrupter = 1'b0;
        int_en      = 1'b1;
        int_ack     = 1'b0;
        eret        = 1'b0;
        resume_pc   = 32'h0;

        // Reset state
        repeat (3) tick();
        chk("rst_int_req", {31'b0, int_req}, 32'h0);
        chk("rst_in_service", {31'b0, in_service}, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_lost", {24'b0, lost_cnt}, 32'h0);
        chk("handler_addr", handler_addr, 32'h0000_0008);
        rst = 1'b0;
        repeat (3) tick();

        // 1. One-clock glitch is rejected
        interrupter = 1'b1;
        tick();
        interrupter = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("glitch_int_req", {31'b0, int_req}, 32'h0);
        end
        chk("glitch_lost", {24'b0, lost_cnt}, 32'h0);

        // 2. Latency: request rises on the 4th edge after the first sampling edge
        interrupter = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("lat_before_edge4", {31'b0, int_req}, 32'h0);
        end
        tick();
        chk("lat_edge4", {31'b0, int_req}, 32'h1);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("lat_held", {31'b0, int_req}, 32'h1);
        end
        chk("lat_one_event", {24'b0, lost_cnt}, 32'h0);
        interrupter = 1'b0;
        repeat (4) tick();
        chk("lat_held_after_low", {31'b0, int_req}, 32'h1);

        // 3. Acknowledge
        int_ack   = 1'b1;
        resume_pc = 32'h0000_0040;
        tick();
        int_ack   = 1'b0;
        chk("ack_int_req", {31'b0, int_req}, 32'h0);
        chk("ack_in_service", {31'b0, in_service}, 32'h1);
        chk("ack_epc", epc, 32'h0000_0040);
        chk("ack_handler", handler_addr, 32'h0000_0008);

        // 4a. Pulse during service is lost
        pulse(4);
        chk("lost_cnt1", {24'b0, lost_cnt}, 32'h1);
        chk("lost_int_req", {31'b0, int_req}, 32'h0);
        chk("lost_in_service", {31'b0, in_service}, 32'h1);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("eret_in_service", {31'b0, in_service}, 32'h0);
        chk("eret_int_req", {31'b0, int_req}, 32'h0);
        repeat (2) tick();
        chk("idle_int_req", {31'b0, int_req}, 32'h0);

        // 4b. Back into service, then eret coincident with a new event
        pulse(4);
        chk("pend_again", {31'b0, int_req}, 32'h1);
        int_ack   = 1'b1;
        resume_pc = 32'h0000_0080;
        tick();
        int_ack   = 1'b0;
        chk("svc_again", {31'b0, in_service}, 32'h1);
        chk("svc_again_epc", epc, 32'h0000_0080);
        repeat (3) tick();
        interrupter = 1'b1;
        repeat (3) tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        interrupter = 1'b0;
        chk("coinc_int_req", {31'b0, int_req}, 32'h1);
        chk("coinc_in_service", {31'b0, in_service}, 32'h0);
        chk("coinc_lost", {24'b0, lost_cnt}, 32'h1);
        repeat (4) tick();

        // 5. Enable masking: return to idle first
        int_ack   = 1'b1;
        resume_pc = 32'h0000_00C0;
        tick();
        int_ack   = 1'b0;
        eret      = 1'b1;
        tick();
        eret      = 1'b0;
        chk("mask_idle", {31'b0, in_service}, 32'h0);
        int_en = 1'b0;
        pulse(4);
        tick();
        chk("mask_int_req", {31'b0, int_req}, 32'h0);
        int_ack   = 1'b1;
        resume_pc = 32'h0000_DEAD;
        tick();
        int_ack   = 1'b0;
        chk("mask_ack_epc", epc, 32'h0000_00C0);
        chk("mask_ack_in_service", {31'b0, in_service}, 32'h0);
        chk("mask_ack_int_req", {31'b0, int_req}, 32'h0);
        int_en = 1'b1;
        #1;
        chk("unmask_same_cycle", {31'b0, int_req}, 32'h1);
        tick();

        // 6. Reset mid-service with epc=0x40 and lost_cnt=3
        int_ack   = 1'b1;
        resume_pc = 32'h0000_0040;
        tick();
        int_ack   = 1'b0;
        repeat (3) tick();
        pulse(4);
        pulse(4);
        chk("pre_rst_lost", {24'b0, lost_cnt}, 32'h3);
        chk("pre_rst_epc", epc, 32'h0000_0040);
        chk("pre_rst_in_service", {31'b0, in_service}, 32'h1);
        rst = 1'b1;
        #1;
        chk("async_rst_int_req", {31'b0, int_req}, 32'h0);
        chk("async_rst_in_service", {31'b0, in_service}, 32'h0);
        chk("async_rst_epc", epc, 32'h0);
        chk("async_rst_lost", {24'b0, lost_cnt}, 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("post_rst_int_req", {31'b0, int_req}, 32'h0);

        // Lost counter saturates at 0xFF
        pulse(4);
        chk("sat_pend", {31'b0, int_req}, 32'h1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 254; k++) pulse(4);
        chk("sat_lost_fe", {24'b0, lost_cnt}, 32'hFE);
        pulse(4);
        chk("sat_lost_ff", {24'b0, lost_cnt}, 32'hFF);
        pulse(4);
        pulse(4);
        chk("sat_lost_hold", {24'b0, lost_cnt}, 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
